// File: rtl/ssram_arb_pkg.sv
// Shared constants for the two-port synchronous SRAM arbiter.
package ssram_arb_pkg;

  localparam int PRIO_RR      = 0;
  localparam int PRIO_FIXED   = 1;
  localparam int MAX_WAIT_DEF = 8;
  localparam int WAIT_W       = 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/arb2_rr.sv
// Two-requester round-robin grant; on a conflict the loser of the previous conflict wins.
module arb2_rr
  import ssram_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01: gnt_o = 2'b01;
      2'b10: gnt_o = 2'b10;
      2'b11: begin
        // last_winner only moves on conflict cycles
        if (last_q == PORT1) begin
          gnt_o  = 2'b01;
          last_d = PORT0;
        end else begin
          gnt_o  = 2'b10;
          last_d = PORT1;
        end
      end
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ssram_arbiter.sv
// Two-port arbiter in front of a single-cycle synchronous SRAM with byte enables.
// Grants are combinational; read data returns one cycle after a granted read.
module ssram_arbiter
  import ssram_arb_pkg::*;
#(
  parameter int AW        = 12,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_WAIT  = MAX_WAIT_DEF
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [3:0]    p0_be,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [3:0]    p1_be,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic [3:0]    sram_enb,
  output logic [3:0]    sram_wb,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [1:0]        req;
  logic [1:0]        rr_gnt;
  logic [1:0]        gnt;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rd_pending_q, rd_pending_d;
  port_e             rd_owner_q, rd_owner_d;

  port_e             sel;
  logic              any_gnt;
  logic              sel_we;
  logic [3:0]        sel_be;
  logic [AW-1:0]     sel_addr;
  logic [31:0]       sel_wdata;

  assign req = {p1_req, p0_req};

  arb2_rr u_arb2_rr (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .req_i  (req),
    .gnt_o  (rr_gnt)
  );

  always_comb begin
    gnt    = 2'b00;
    wait_d = wait_q;
    if (PRIO_MODE == PRIO_FIXED) begin
      // port 1 is forced through once it has been starved MAX_WAIT times
      if (&req) begin
        gnt = (wait_q == MAX_WAIT_C) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt[1]) begin
        wait_d = '0;
      end else if (req[1]) begin
        wait_d = wait_q + 1'b1;
      end
    end else begin
      gnt    = rr_gnt;
      wait_d = '0;
    end
    if (!HRESETn) begin
      gnt = 2'b00;
    end
  end

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  always_comb begin
    any_gnt   = |gnt;
    sel       = gnt[1] ? PORT1 : PORT0;
    sel_we    = gnt[1] ? p1_we    : p0_we;
    sel_be    = gnt[1] ? p1_be    : p0_be;
    sel_addr  = gnt[1] ? p1_addr  : p0_addr;
    sel_wdata = gnt[1] ? p1_wdata : p0_wdata;

    sram_enb  = 4'h0;
    sram_wb   = 4'h0;
    sram_addr = '0;
    sram_din  = 32'h0;
    if (any_gnt) begin
      sram_enb  = sel_be;
      sram_wb   = sel_we ? sel_be : 4'h0;
      sram_addr = sel_addr;
      sram_din  = sel_wdata;
    end

    // a zero byte-enable read occupies the slot but never returns data
    rd_pending_d = any_gnt && !sel_we && (|sel_be);
    rd_owner_d   = rd_pending_d ? sel : rd_owner_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_q       <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= PORT0;
    end else begin
      wait_q       <= wait_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign p0_rvalid = rd_pending_q && (rd_owner_q == PORT0);
  assign p1_rvalid = rd_pending_q && (rd_owner_q == PORT1);
  assign p0_rdata  = sram_dout;
  assign p1_rdata  = sram_dout;

endmodule
